// File: rtl/f_npc_fetch.sv
// rtl/f_npc_fetch.sv - fetch-stage PC register, IM handshake and delay-slot redirect (optional NPC_ALIGN_CHECK_EN)
module f_npc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        D_valid,
  input  logic [1:0]  NPCSel,
  input  logic        BranchtoJump,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] RD1rs,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
`ifdef NPC_ALIGN_CHECK_EN
  output logic        F_AdEL,
`endif
  output logic        F_valid
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pend_v_q;
  logic [31:0] pend_tgt_q;
  logic [31:0] f_pc_q;
  logic [31:0] f_instr_q;
  logic        f_valid_q;
  logic        f_adel_q;

  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] br_tgt;
  logic        misal;
  logic        fetch_done;
  logic [31:0] instr_in;

  // D-stage redirect decision and target; a stalled D stage never redirects
  always_comb begin
    br_tgt    = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    redir_tgt = br_tgt;
    case (NPCSel)
      2'd2:    redir_tgt = {D_PC[31:28], D_imm26, 2'b00};
      2'd3:    redir_tgt = RD1rs;
      default: redir_tgt = br_tgt;
    endcase
    redir = D_valid & ~stall &
            ((NPCSel == 2'd2) | (NPCSel == 2'd3) | ((NPCSel == 2'd1) & BranchtoJump));
  end

  // Next PC once the delay-slot fetch retires: live redirect beats a parked one
  always_comb begin
    if (redir) begin
      pc_d = redir_tgt;
    end else if (pend_v_q) begin
      pc_d = pend_tgt_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Misaligned PCs complete locally as a faulting slot instead of going to IM
  always_comb begin
`ifdef NPC_ALIGN_CHECK_EN
    misal   = (pc_q[1:0] != 2'b00);
    im_addr = pc_q;
`else
    misal   = 1'b0;
    im_addr = {pc_q[31:2], 2'b00};
`endif
    fetch_done = im_ready | misal;
    instr_in   = misal ? 32'h0 : im_rdata;
    im_req     = (state_q == S_FETCH) & ~reset & ~misal;
  end

  // Fetch FSM: PC, parked redirect target and F-stage output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= RESET_PC;
      f_pc_q     <= RESET_PC;
      f_instr_q  <= 32'h0;
      f_valid_q  <= 1'b0;
      f_adel_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fetch_done) begin
            f_instr_q <= instr_in;
            f_pc_q    <= pc_q;
            f_valid_q <= 1'b1;
            f_adel_q  <= misal;
            if (!stall) begin
              pc_q     <= pc_d;
              pend_v_q <= 1'b0;
            end else begin
              state_q <= S_HOLD;
            end
          end else begin
            f_valid_q <= 1'b0;
            f_adel_q  <= 1'b0;
            if (redir) begin
              pend_tgt_q <= redir_tgt;
              pend_v_q   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_q      <= pc_d;
            pend_v_q  <= 1'b0;
            f_valid_q <= 1'b0;
            f_adel_q  <= 1'b0;
            state_q   <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign F_PC    = f_pc_q;
  assign F_Instr = f_instr_q;
  assign F_valid = f_valid_q;
`ifdef NPC_ALIGN_CHECK_EN
  assign F_AdEL  = f_adel_q;
`else
  logic unused_adel;
  assign unused_adel = f_adel_q;
`endif

endmodule

// File: tb/tb_f_npc_fetch.sv
// tb/tb_f_npc_fetch.sv - directed-vector bench for f_npc_fetch
module tb_f_npc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        D_valid;
  logic [1:0]  NPCSel;
  logic        BranchtoJump;
  logic [31:0] D_PC;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] RD1rs;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_valid;
`ifdef NPC_ALIGN_CHECK_EN
  logic        F_AdEL;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // instruction memory: each word tagged with its own address
  assign im_rdata = im_addr ^ 32'hDEAD_0000;

  f_npc_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .D_valid(D_valid),
    .NPCSel(NPCSel), .BranchtoJump(BranchtoJump), .D_PC(D_PC),
    .D_imm16(D_imm16), .D_imm26(D_imm26), .RD1rs(RD1rs),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rdata(im_rdata), .F_PC(F_PC), .F_Instr(F_Instr),
`ifdef NPC_ALIGN_CHECK_EN
    .F_AdEL(F_AdEL),
`endif
    .F_valid(F_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_clear();
    D_valid = 1'b0; NPCSel = 2'd0; BranchtoJump = 1'b0;
    D_PC = 32'h0; D_imm16 = 16'h0; D_imm26 = 26'h0; RD1rs = 32'h0;
  endtask

  task automatic d_set(input logic [1:0] sel, input logic btj, input logic [31:0] pc,
                       input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
    D_valid = 1'b1; NPCSel = sel; BranchtoJump = btj;
    D_PC = pc; D_imm16 = i16; D_imm26 = i26; RD1rs = rs;
  endtask

  task automatic chk_f(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] addr);
    check_val({tag, ".F_valid"}, {31'h0, F_valid}, {31'h0, v});
    check_val({tag, ".F_PC"}, F_PC, pc);
    check_val({tag, ".im_addr"}, im_addr, addr);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; im_ready = 1'b1;
    d_clear();
    #1;
    check_val("rst.im_req", {31'h0, im_req}, 32'h0);
    step();
    step();
    check_val("rst.F_valid", {31'h0, F_valid}, 32'h0);
    check_val("rst.F_Instr", F_Instr, 32'h0);
    check_val("rst.F_PC", F_PC, 32'h3000);
`ifdef NPC_ALIGN_CHECK_EN
    check_val("rst.F_AdEL", {31'h0, F_AdEL}, 32'h0);
`endif
    reset = 1'b0;
    #1;
    check_val("t1.im_req", {31'h0, im_req}, 32'h1);
    check_val("t1.im_addr0", im_addr, 32'h3000);

    // 1: sequential single-cycle fetch
    step();
    chk_f("t1.c2", 1'b1, 32'h3000, 32'h3004);
    check_val("t1.F_Instr", F_Instr, 32'hDEAD_3000);
    step();
    chk_f("t1.c3", 1'b1, 32'h3004, 32'h3008);

    // branch not taken: sequential flow continues
    d_set(2'd1, 1'b0, 32'h3004, 16'h0010, 26'h0, 32'h0);
    step();
    chk_f("nt", 1'b1, 32'h3008, 32'h300C);

    // 2: taken beq at 3008, offset -2 words: 3008+4-8 = 3004
    d_set(2'd1, 1'b1, 32'h3008, 16'hFFFE, 26'h0, 32'h0);
    step();
    chk_f("t2.slot", 1'b1, 32'h300C, 32'h3004);
    check_val("t2.F_Instr", F_Instr, 32'hDEAD_300C);
    d_clear();
    for (int i = 0; i < 4; i++) step();
    check_val("t2.seq", im_addr, 32'h3014);

    // 3: jal while IM not ready; target parked, delivered after delay slot
    im_ready = 1'b0;
    d_set(2'd2, 1'b0, 32'h3010, 16'h0, 26'h0000C10, 32'h0);
    step();
    chk_f("t3.w1", 1'b0, 32'h3010, 32'h3014);
    check_val("t3.im_req", {31'h0, im_req}, 32'h1);
    d_clear();
    step();
    chk_f("t3.w2", 1'b0, 32'h3010, 32'h3014);
    im_ready = 1'b1;
    step();
    chk_f("t3.slot", 1'b1, 32'h3014, 32'h3040);
    check_val("t3.F_Instr", F_Instr, 32'hDEAD_3014);

    // reposition to 3020 via jr
    d_set(2'd3, 1'b0, 32'h3030, 16'h0, 26'h0, 32'h3020);
    step();
    chk_f("jr3020", 1'b1, 32'h3040, 32'h3020);
    d_clear();

    // 4: stall three cycles with response at 3020
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_f("t4.hold", 1'b1, 32'h3020, 32'h3020);
      check_val("t4.im_req", {31'h0, im_req}, 32'h0);
      check_val("t4.F_Instr", F_Instr, 32'hDEAD_3020);
    end
    stall = 1'b0;
    step();
    chk_f("t4.rel", 1'b0, 32'h3020, 32'h3024);
    check_val("t4.im_req1", {31'h0, im_req}, 32'h1);

    // 5: jr held during stall does not redirect until release
    stall = 1'b1;
    d_set(2'd3, 1'b0, 32'h3020, 16'h0, 26'h0, 32'h0000_3100);
    step();
    chk_f("t5.s1", 1'b1, 32'h3024, 32'h3024);
    check_val("t5.im_req", {31'h0, im_req}, 32'h0);
    step();
    chk_f("t5.s2", 1'b1, 32'h3024, 32'h3024);
    stall = 1'b0;
    step();
    chk_f("t5.rel", 1'b0, 32'h3024, 32'h3100);
    d_clear();
    step();
    chk_f("t5.tgt", 1'b1, 32'h3100, 32'h3104);

    // 6: misaligned jr target
    d_set(2'd3, 1'b0, 32'h30F0, 16'h0, 26'h0, 32'h0000_3102);
    step();
    d_clear();
`ifdef NPC_ALIGN_CHECK_EN
    check_val("t6.im_req", {31'h0, im_req}, 32'h0);
    check_val("t6.F_PC0", F_PC, 32'h3104);
    step();
    check_val("t6.F_valid", {31'h0, F_valid}, 32'h1);
    check_val("t6.F_PC", F_PC, 32'h3102);
    check_val("t6.F_Instr", F_Instr, 32'h0);
    check_val("t6.F_AdEL", {31'h0, F_AdEL}, 32'h1);
`else
    check_val("t6.im_req", {31'h0, im_req}, 32'h1);
    check_val("t6.im_addr", im_addr, 32'h3100);
    step();
    check_val("t6.F_Instr", F_Instr, 32'hDEAD_3100);
`endif

    // reset mid-stream with im_ready high: response ignored
    reset = 1'b1;
    im_ready = 1'b1;
    #1;
    check_val("rst2.im_req", {31'h0, im_req}, 32'h0);
    step();
    check_val("rst2.F_valid", {31'h0, F_valid}, 32'h0);
    check_val("rst2.F_Instr", F_Instr, 32'h0);
    check_val("rst2.F_PC", F_PC, 32'h3000);
`ifdef NPC_ALIGN_CHECK_EN
    check_val("rst2.F_AdEL", {31'h0, F_AdEL}, 32'h0);
`endif
    reset = 1'b0;
    #1;
    check_val("rst2.im_addr", im_addr, 32'h3000);
    check_val("rst2.im_req1", {31'h0, im_req}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
